reorder_buffer: RTL

In-order retirement buffer on the consumer side of the rename/dispatch stage. Allocates up to SS ROB IDs per cycle and advertises them to dispatch ahead of time. Accepts the dispatch entries and marks entries complete on writeback. Retires up to SS contiguous completed entries per cycle from the head to the RRAT and RVFI, assigning the RVFI order number.

---
 rtl/reorder_buffer_pkg.sv | 55 +++++
 rtl/reorder_buffer_retire_select.sv | 32 +++
 rtl/reorder_buffer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: dispatch/RVFI packets, ROB entry and ID types.
// Defaults here size the entry fields; the ROB parameters must match them.
package reorder_buffer_pkg;

    localparam int ROB_DEPTH_DFLT  = 8;
    localparam int PR_ENTRIES_DFLT = 64;
    localparam int ROB_ID_W        = $clog2(ROB_DEPTH_DFLT);
    localparam int PR_W            = $clog2(PR_ENTRIES_DFLT);

    typedef logic [ROB_ID_W-1:0] rob_id_t;
    typedef logic [PR_W-1:0]     phys_reg_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] order;
        logic [31:0] inst;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
    } rvfi_t;

    typedef struct packed {
        rob_id_t rob_id;
    } rob_info_t;

    typedef struct packed {
        logic [4:0] rd_s;
    } inst_info_t;

    typedef struct packed {
        phys_reg_t rd;
    } rat_info_t;

    typedef struct packed {
        rob_info_t  rob;
        rvfi_t      rvfi;
        inst_info_t inst;
        rat_info_t  rat;
    } super_dispatch_t;

    typedef struct packed {
        logic       valid;
        logic       done;
        logic       is_real;
        logic [4:0] isa_rd;
        phys_reg_t  phys_rd;
        rvfi_t      rvfi;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_retire_select.sv
// Combinational prefix scan over the SS entries at the head: retire mask, retire count,
// count of real retirements and per-slot order offsets (real slots retiring before it).
module reorder_buffer_retire_select #(
    parameter int SS = 2
) (
    input  logic [SS-1:0]            valid_i,
    input  logic [SS-1:0]            done_i,
    input  logic [SS-1:0]            real_i,
    output logic [SS-1:0]            retire_o,
    output logic [$clog2(SS+1)-1:0]  n_o,
    output logic [$clog2(SS+1)-1:0]  n_real_o,
    output logic [$clog2(SS+1)-1:0]  offset_o [SS]
);

    localparam int CW = $clog2(SS + 1);

    always_comb begin
        logic run;
        run      = 1'b1;
        n_o      = '0;
        n_real_o = '0;
        retire_o = '0;
        for (int k = 0; k < SS; k++) begin
            offset_o[k] = n_real_o;
            run         = run & valid_i[k] & done_i[k];
            retire_o[k] = run;
            n_o         = n_o + CW'(run);
            n_real_o    = n_real_o + CW'(run & real_i[k]);
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates SS IDs per cycle, completes on writeback, retires up to SS.
// Commit outputs are combinational from registered state; rob_full stalls dispatch (no same-cycle credit).
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int SS         = 2,
    parameter int ROB_DEPTH  = ROB_DEPTH_DFLT,
    parameter int PR_ENTRIES = PR_ENTRIES_DFLT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          dispatch_valid,
    input  super_dispatch_t               dispatch_entry [SS],
    output logic [$clog2(ROB_DEPTH)-1:0]  rob_id_next [SS],
    output logic                          rob_full,
    input  logic [SS-1:0]                 wb_valid,
    input  logic [$clog2(ROB_DEPTH)-1:0]  wb_rob_id [SS],
    input  logic [31:0]                   wb_rd_wdata [SS],
    output logic [SS-1:0]                 commit_valid,
    output logic [4:0]                    commit_isa_rd [SS],
    output logic [$clog2(PR_ENTRIES)-1:0] commit_phys_rd [SS],
    output logic [SS-1:0]                 commit_rd_we,
    output rvfi_t                         commit_rvfi [SS]
);

    localparam int IW = $clog2(ROB_DEPTH);
    localparam int PW = IW + 1;
    localparam int CW = $clog2(SS + 1);
    localparam int RW = $clog2(PR_ENTRIES);

    rob_entry_t    rob_q [ROB_DEPTH];
    rob_entry_t    rob_d [ROB_DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] count;
    logic [63:0]   order_q, order_d;
    logic          alloc;

    logic [IW-1:0] win_idx [SS];
    logic [SS-1:0] win_valid, win_done, win_real, retire;
    logic [CW-1:0] n_ret, n_real;
    logic [CW-1:0] order_ofs [SS];

    // Wrap bit in the MSB makes tail - head the true occupancy, including full.
    assign count    = tail_q - head_q;
    assign rob_full = (PW'(ROB_DEPTH) - count) < PW'(SS);
    assign alloc    = dispatch_valid && !rob_full;

    always_comb begin
        for (int k = 0; k < SS; k++) begin
            win_idx[k]     = head_q[IW-1:0] + IW'(k);
            rob_id_next[k] = tail_q[IW-1:0] + IW'(k);
            win_valid[k]   = rob_q[win_idx[k]].valid;
            win_done[k]    = rob_q[win_idx[k]].done;
            win_real[k]    = rob_q[win_idx[k]].is_real;
        end
    end

    reorder_buffer_retire_select #(.SS(SS)) u_retire_select (
        .valid_i  (win_valid),
        .done_i   (win_done),
        .real_i   (win_real),
        .retire_o (retire),
        .n_o      (n_ret),
        .n_real_o (n_real),
        .offset_o (order_ofs)
    );

    always_comb begin
        for (int k = 0; k < SS; k++) begin
            commit_valid[k]       = retire[k] && rob_q[win_idx[k]].is_real;
            commit_rd_we[k]       = commit_valid[k] && (rob_q[win_idx[k]].isa_rd != 5'd0);
            commit_isa_rd[k]      = rob_q[win_idx[k]].isa_rd;
            commit_phys_rd[k]     = RW'(rob_q[win_idx[k]].phys_rd);
            commit_rvfi[k]        = rob_q[win_idx[k]].rvfi;
            commit_rvfi[k].order  = order_q + 64'(order_ofs[k]);
            commit_rvfi[k].valid  = commit_valid[k];
        end
    end

    always_comb begin
        rob_d = rob_q;
        for (int p = 0; p < SS; p++) begin
            if (wb_valid[p] && rob_q[wb_rob_id[p]].valid) begin
                rob_d[wb_rob_id[p]].done          = 1'b1;
                rob_d[wb_rob_id[p]].rvfi.rd_wdata = wb_rd_wdata[p];
            end
        end
        if (alloc) begin
            for (int i = 0; i < SS; i++) begin
                rob_d[IW'(dispatch_entry[i].rob.rob_id)] = '{
                    valid:   1'b1,
                    done:    !dispatch_entry[i].rvfi.valid,
                    is_real: dispatch_entry[i].rvfi.valid,
                    isa_rd:  dispatch_entry[i].inst.rd_s,
                    phys_rd: dispatch_entry[i].rat.rd,
                    rvfi:    dispatch_entry[i].rvfi
                };
            end
        end
        // Retirement clears last so a late writeback cannot resurrect a retired slot.
        for (int k = 0; k < SS; k++) begin
            if (retire[k]) begin
                rob_d[win_idx[k]].valid = 1'b0;
                rob_d[win_idx[k]].done  = 1'b0;
            end
        end
        head_d  = head_q + PW'(n_ret);
        tail_d  = alloc ? tail_q + PW'(SS) : tail_q;
        order_d = order_q + 64'(n_real);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            order_q <= '0;
            for (int e = 0; e < ROB_DEPTH; e++) begin
                rob_q[e] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            order_q <= order_d;
            rob_q   <= rob_d;
        end
    end

endmodule
